// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad code-lock controller.
//   KEY_CLEAR / KEY_ENTER : special key codes from the keypad scanner
//   DIGIT_W               : width of one BCD digit
//   state_t               : controller state encoding
//   is_digit()            : true for key codes 0-9
package keylock_pkg;

   localparam int         DIGIT_W   = 4;
   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ENTRY     = 3'd1,
      ST_CHECK     = 3'd2,
      ST_NEW_CODE  = 3'd3,
      ST_CONFIRM   = 3'd4,
      ST_CHECK_CFM = 3'd5,
      ST_LOCKOUT   = 3'd6
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/keylock_code_entry_buffer.sv
// Code entry buffer: collects BCD digits into a shift register.
//   hwclk, reset  : clock, synchronous active-high reset
//   clear         : empty the buffer and drop the overflow flag (wins over digit_valid)
//   digit_valid   : shift digit in at the LSB end
//   digit         : BCD digit 0-9
//   code_buf      : buffered code, most recently entered digit in the low nibble
//   count         : number of digits held (0..NUM_DIGITS)
//   valid_full    : exactly NUM_DIGITS digits entered and none dropped
module code_entry_buffer
   import keylock_pkg::*;
#(
   parameter int NUM_DIGITS = 6
) (
   input  logic                        hwclk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        digit_valid,
   input  logic [3:0]                  digit,
   output logic [DIGIT_W*NUM_DIGITS-1:0] code_buf,
   output logic [3:0]                  count,
   output logic                        valid_full
);

   localparam int CW = DIGIT_W * NUM_DIGITS;

   logic overflow;

   always_ff @(posedge hwclk) begin
      if (reset || clear) begin
         code_buf <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (digit_valid) begin
         if (count < 4'(NUM_DIGITS)) begin
            code_buf <= (code_buf << DIGIT_W) | CW'(digit);
            count    <= count + 4'd1;
         end else begin
            // a digit past the code length poisons the entry until cleared
            overflow <= 1'b1;
         end
      end
   end

   assign valid_full = (count == 4'(NUM_DIGITS)) && !overflow;

endmodule

// File: rtl/keylock_core.sv
// Keypad code-lock controller.
// Checks an NUM_DIGITS-digit BCD code against the user code or the master
// (programming) code, toggles the lock, lets the user code be reprogrammed
// with a confirm step, and locks the keypad out after repeated failures.
//   hwclk          : system clock
//   reset          : synchronous active-high reset, dominates everything
//   key_valid, key : one-cycle key strobe; 0-9 digit, A clear, B enter, C-F ignored
//   locked         : lock state
//   ok_pulse       : one-cycle strobe, lock/unlock or new code accepted
//   err_pulse      : one-cycle strobe, rejected submit
//   lockout        : high for the whole lockout window
//   prog_mode      : high while entering / confirming a new code
//   digits_entered : digits in the entry buffer
//   fail_count     : consecutive failed submits while locked
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for the first digit, buffer empty
// ST_ENTRY     | collecting a code for unlock / lock / master check
// ST_CHECK     | one cycle: compare buffer with master and user code
// ST_NEW_CODE  | programming: collecting the new user code
// ST_CONFIRM   | programming: collecting the confirmation of the new code
// ST_CHECK_CFM | one cycle: compare confirmation with the candidate
// ST_LOCKOUT   | too many failures, all keys ignored until the timer ends
module keylock_core
   import keylock_pkg::*;
#(
   parameter int                      NUM_DIGITS     = 6,
   parameter logic [4*NUM_DIGITS-1:0] MASTER_CODE    = 24'h555116,
   parameter logic [4*NUM_DIGITS-1:0] USER_DEFAULT   = 24'h666666,
   parameter int                      MAX_FAILS      = 3,
   parameter int                      LOCKOUT_CYCLES = 60000000,
   parameter int                      ENTRY_TIMEOUT  = 120000000
) (
   input  logic       hwclk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key,
   output logic       locked,
   output logic       ok_pulse,
   output logic       err_pulse,
   output logic       lockout,
   output logic       prog_mode,
   output logic [3:0] digits_entered,
   output logic [3:0] fail_count
);

   localparam int CW   = DIGIT_W * NUM_DIGITS;
   localparam int LT_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam int ET_W = $clog2(ENTRY_TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     code_buf;
   logic              valid_full;
   logic [CW-1:0]     user_code_q;
   logic [CW-1:0]     cand_q;
   logic [3:0]        fail_q;
   logic              locked_q;
   logic              err_pend_q;
   logic [LT_W-1:0]   lock_tmr;
   logic [ET_W-1:0]   entry_tmr;

   logic key_dig, key_clr, key_ent;
   logic accept_key, timed, timeout, lock_done;
   logic master_hit, user_hit, cand_hit, fail_limit;

   logic buf_digit, buf_clear;
   logic ok_set, err_set, err_defer;
   logic lock_toggle, fail_clr, fail_inc;
   logic cand_load, user_load;

   assign key_dig = key_valid && is_digit(key);
   assign key_clr = key_valid && (key == KEY_CLEAR);
   assign key_ent = key_valid && (key == KEY_ENTER);

   assign accept_key = (state_q == ST_IDLE) || (state_q == ST_ENTRY) ||
                       (state_q == ST_NEW_CODE) || (state_q == ST_CONFIRM);
   assign timed      = (state_q == ST_ENTRY) || (state_q == ST_NEW_CODE) ||
                       (state_q == ST_CONFIRM);
   assign timeout    = timed && !key_valid && (entry_tmr <= ET_W'(1));
   assign lock_done  = (lock_tmr <= LT_W'(1));

   // master is tested first so it wins even if the user code equals it
   assign master_hit = valid_full && (code_buf == MASTER_CODE);
   assign user_hit   = valid_full && (code_buf == user_code_q);
   assign cand_hit   = valid_full && (code_buf == cand_q);
   assign fail_limit = (int'(fail_q) + 1 >= MAX_FAILS);

   code_entry_buffer #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_buf (
      .hwclk       (hwclk),
      .reset       (reset),
      .clear       (buf_clear),
      .digit_valid (buf_digit),
      .digit       (key),
      .code_buf    (code_buf),
      .count       (digits_entered),
      .valid_full  (valid_full)
   );

   always_ff @(posedge hwclk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (key_dig) state_d = ST_ENTRY;
         ST_ENTRY: begin
            if (timeout)      state_d = ST_IDLE;
            else if (key_ent) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (master_hit)                state_d = ST_NEW_CODE;
            else if (user_hit)             state_d = ST_IDLE;
            else if (locked_q && fail_limit) state_d = ST_LOCKOUT;
            else                           state_d = ST_IDLE;
         end
         ST_NEW_CODE: begin
            if (timeout)      state_d = ST_IDLE;
            else if (key_ent) state_d = valid_full ? ST_CONFIRM : ST_IDLE;
         end
         ST_CONFIRM: begin
            if (timeout)      state_d = ST_IDLE;
            else if (key_ent) state_d = ST_CHECK_CFM;
         end
         ST_CHECK_CFM: state_d = ST_IDLE;
         ST_LOCKOUT:   if (lock_done) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      prog_mode   = (state_q == ST_NEW_CODE) || (state_q == ST_CONFIRM);
      lockout     = (state_q == ST_LOCKOUT);
      buf_digit   = accept_key && key_dig;
      buf_clear   = accept_key && key_clr;
      ok_set      = 1'b0;
      err_set     = 1'b0;
      err_defer   = 1'b0;
      lock_toggle = 1'b0;
      fail_clr    = 1'b0;
      fail_inc    = 1'b0;
      cand_load   = 1'b0;
      user_load   = 1'b0;
      case (state_q)
         ST_ENTRY, ST_CONFIRM: if (timeout) buf_clear = 1'b1;
         ST_NEW_CODE: begin
            if (timeout) begin
               buf_clear = 1'b1;
            end else if (key_ent) begin
               buf_clear = 1'b1;
               if (valid_full) cand_load = 1'b1;
               else            err_defer = 1'b1;
            end
         end
         ST_CHECK: begin
            buf_clear = 1'b1;
            if (master_hit) begin
               // enter programming silently
            end else if (user_hit) begin
               ok_set      = 1'b1;
               lock_toggle = 1'b1;
               fail_clr    = 1'b1;
            end else begin
               err_set  = 1'b1;
               fail_inc = locked_q;
            end
         end
         ST_CHECK_CFM: begin
            buf_clear = 1'b1;
            if (cand_hit) begin
               user_load = 1'b1;
               ok_set    = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         ST_LOCKOUT: if (lock_done) fail_clr = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge hwclk) begin
      if (reset) begin
         locked_q    <= 1'b0;
         ok_pulse    <= 1'b0;
         err_pulse   <= 1'b0;
         err_pend_q  <= 1'b0;
         fail_q      <= '0;
         user_code_q <= USER_DEFAULT;
         cand_q      <= '0;
         lock_tmr    <= '0;
         entry_tmr   <= '0;
      end else begin
         ok_pulse   <= ok_set;
         // an invalid new code is rejected straight from NEW_CODE; the
         // extra stage keeps its error pulse at the same latency as a CHECK
         err_pend_q <= err_defer;
         err_pulse  <= err_set || err_pend_q;

         if (lock_toggle) locked_q <= !locked_q;

         if (fail_clr)
            fail_q <= '0;
         else if (fail_inc && (fail_q < 4'(MAX_FAILS)))
            fail_q <= fail_q + 4'd1;

         if (cand_load) cand_q      <= code_buf;
         if (user_load) user_code_q <= cand_q;

         if (state_q != ST_LOCKOUT)
            lock_tmr <= LT_W'(LOCKOUT_CYCLES);
         else if (lock_tmr != '0)
            lock_tmr <= lock_tmr - LT_W'(1);

         if (key_valid || !timed)
            entry_tmr <= ET_W'(ENTRY_TIMEOUT);
         else if (entry_tmr != '0)
            entry_tmr <= entry_tmr - ET_W'(1);
      end
   end

   assign locked     = locked_q;
   assign fail_count = fail_q;

endmodule

// File: tb/tb_keylock_core.sv
module tb_keylock_core;
   import keylock_pkg::*;

   localparam int N  = 6;
   localparam int CW = 4 * N;
   localparam int MF = 3;
   localparam int LC = 40;
   localparam int ET = 30;
   localparam logic [CW-1:0] MASTER = 24'h555116;
   localparam logic [CW-1:0] UDEF   = 24'h666666;

   localparam int M_IDLE = 0, M_ENTRY = 1, M_NEW = 2, M_CFM = 3;
   localparam int K_SUBMIT = 0, K_CONFIRM = 1;

   logic hwclk = 1'b0;
   logic reset, key_valid;
   logic [3:0] key;
   logic locked, ok_pulse, err_pulse, lockout, prog_mode;
   logic [3:0] digits_entered, fail_count;

   keylock_core #(
      .NUM_DIGITS(N), .MASTER_CODE(MASTER), .USER_DEFAULT(UDEF),
      .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET)
   ) dut (
      .hwclk(hwclk), .reset(reset), .key_valid(key_valid), .key(key),
      .locked(locked), .ok_pulse(ok_pulse), .err_pulse(err_pulse),
      .lockout(lockout), .prog_mode(prog_mode),
      .digits_entered(digits_entered), .fail_count(fail_count)
   );

   always #5 hwclk = ~hwclk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // behavioural model: values expected during the next cycle
   bit            m_lock, m_ok, m_err, m_lockout;
   int            m_fails;
   logic [CW-1:0] m_user, m_cand;
   int            q[$];
   bit            ovf;
   int            mode, idle_cnt, lock_left;
   bit            pend, defer;
   int            pend_kind;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] q_value();
      logic [CW-1:0] v = '0;
      foreach (q[i]) v = (v << 4) | CW'(q[i]);
      return v;
   endfunction

   function automatic void model_reset();
      m_lock = 0; m_ok = 0; m_err = 0; m_lockout = 0; m_fails = 0;
      m_user = UDEF; m_cand = '0; q.delete(); ovf = 0;
      mode = M_IDLE; idle_cnt = 0; lock_left = 0; pend = 0; defer = 0; pend_kind = 0;
   endfunction

   function automatic void model_step(input logic v, input logic [3:0] k, input logic r);
      bit            valid;
      logic [CW-1:0] val;
      if (r) begin
         model_reset();
         return;
      end
      valid = (q.size() == N) && !ovf;
      val   = q_value();
      m_ok  = 0;
      m_err = defer;
      defer = 0;
      if (pend) begin
         pend = 0;
         if (pend_kind == K_SUBMIT) begin
            if (valid && val == MASTER) begin
               mode = M_NEW; idle_cnt = 0;
            end else if (valid && val == m_user) begin
               m_lock = !m_lock; m_ok = 1; m_fails = 0; mode = M_IDLE;
            end else begin
               m_err = 1; mode = M_IDLE;
               if (m_lock) begin
                  if (m_fails < MF) m_fails++;
                  if (m_fails >= MF) begin
                     m_lockout = 1; lock_left = LC;
                  end
               end
            end
         end else begin
            if (valid && val == m_cand) begin
               m_user = m_cand; m_ok = 1;
            end else m_err = 1;
            mode = M_IDLE;
         end
         q.delete(); ovf = 0;
      end else if (m_lockout) begin
         lock_left--;
         if (lock_left == 0) begin
            m_lockout = 0; m_fails = 0;
         end
      end else if (v) begin
         idle_cnt = 0;
         if (k <= 4'd9) begin
            if (mode == M_IDLE) mode = M_ENTRY;
            if (q.size() < N) q.push_back(int'(k));
            else ovf = 1;
         end else if (k == KEY_CLEAR) begin
            q.delete(); ovf = 0;
         end else if (k == KEY_ENTER) begin
            if (mode == M_ENTRY) begin
               pend = 1; pend_kind = K_SUBMIT;
            end else if (mode == M_CFM) begin
               pend = 1; pend_kind = K_CONFIRM;
            end else if (mode == M_NEW) begin
               if (valid) begin
                  m_cand = val; mode = M_CFM;
               end else begin
                  defer = 1; mode = M_IDLE;
               end
               q.delete(); ovf = 0;
            end
         end
      end else if (mode != M_IDLE) begin
         idle_cnt++;
         if (idle_cnt >= ET) begin
            mode = M_IDLE; q.delete(); ovf = 0;
         end
      end
   endfunction

   always @(negedge hwclk) begin
      if (chk_en) begin
         check("locked",     32'(locked),         32'(m_lock));
         check("ok_pulse",   32'(ok_pulse),       32'(m_ok));
         check("err_pulse",  32'(err_pulse),      32'(m_err));
         check("lockout",    32'(lockout),        32'(m_lockout));
         check("prog_mode",  32'(prog_mode),      32'((mode == M_NEW || mode == M_CFM) && !pend));
         check("digits",     32'(digits_entered), 32'(q.size()));
         check("fail_count", 32'(fail_count),     32'(m_fails));
      end
   end

   task automatic cyc(input logic v, input logic [3:0] k, input logic r);
      key_valid = v; key = k; reset = r;
      @(posedge hwclk);
      model_step(v, k, r);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 4'h0, 1'b0);
   endtask

   task automatic press(input logic [3:0] k);
      cyc(1'b1, k, 1'b0);
   endtask

   task automatic type_code(input logic [CW-1:0] c);
      for (int i = 0; i < N; i++) press(c[4*(N-1-i) +: 4]);
   endtask

   task automatic submit(input logic [CW-1:0] c);
      type_code(c);
      press(KEY_ENTER);
   endtask

   logic [CW-1:0] code;
   int            nd, sel, rr;

   initial begin
      model_reset();
      reset = 1'b1; key_valid = 1'b0; key = 4'h0;
      cyc(1'b0, 4'h0, 1'b1);
      chk_en = 1;
      cyc(1'b0, 4'h0, 1'b1);
      idle(1);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_digits", 32'(digits_entered), 32'd0);
      check("rst_prog", 32'(prog_mode), 32'd0);

      // 1: default user code locks
      submit(24'h666666);
      idle(1);
      check("t1_ok_t2", 32'(ok_pulse), 32'd1);
      check("t1_locked", 32'(locked), 32'd1);
      check("t1_fails", 32'(fail_count), 32'd0);
      idle(1);

      // 2: three wrong submits while locked -> lockout
      for (int i = 0; i < 3; i++) begin
         submit(24'h123456);
         idle(1);
         check("t2_err", 32'(err_pulse), 32'd1);
         check("t2_fails", 32'(fail_count), 32'(i + 1));
         idle(1);
      end
      check("t2_lockout", 32'(lockout), 32'd1);
      submit(24'h666666);
      for (int i = 0; i < 15; i++) press(4'($urandom_range(0, 15)));
      idle(LC);
      check("t2_lock_end", 32'(lockout), 32'd0);
      check("t2_fail_clr", 32'(fail_count), 32'd0);
      check("t2_still_locked", 32'(locked), 32'd1);

      // 3: program 123456
      submit(MASTER);
      idle(1);
      check("t3_prog", 32'(prog_mode), 32'd1);
      submit(24'h123456);
      check("t3_prog_cfm", 32'(prog_mode), 32'd1);
      submit(24'h123456);
      idle(1);
      check("t3_ok", 32'(ok_pulse), 32'd1);
      check("t3_locked_same", 32'(locked), 32'd1);
      idle(1);
      submit(24'h666666);
      idle(1);
      check("t3_old_err", 32'(err_pulse), 32'd1);
      idle(1);
      submit(24'h123456);
      idle(1);
      check("t3_new_ok", 32'(ok_pulse), 32'd1);
      check("t3_unlocked", 32'(locked), 32'd0);
      idle(1);

      // 4: bad confirm, short and long codes
      submit(MASTER);
      idle(1);
      submit(24'h123456);
      submit(24'h123457);
      idle(1);
      check("t4_cfm_err", 32'(err_pulse), 32'd1);
      idle(1);
      submit(24'h123456);
      idle(1);
      check("t4_code_kept", 32'(ok_pulse), 32'd1);
      idle(1);
      for (int i = 1; i <= 5; i++) press(4'(i));
      press(KEY_ENTER);
      idle(1);
      check("t4_short_err", 32'(err_pulse), 32'd1);
      idle(1);
      for (int i = 1; i <= 7; i++) press(4'(i));
      check("t4_sat_digits", 32'(digits_entered), 32'd6);
      press(KEY_ENTER);
      idle(1);
      check("t4_long_err", 32'(err_pulse), 32'd1);
      check("t4_fails", 32'(fail_count), 32'd2);
      idle(1);
      submit(24'h123456);
      idle(2);

      // 5: entry timeout and clear
      press(4'd1); press(4'd2); press(4'd3);
      idle(ET);
      check("t5_timeout_digits", 32'(digits_entered), 32'd0);
      press(4'd9); press(4'd8); press(4'd7);
      press(KEY_CLEAR);
      submit(24'h123456);
      idle(1);
      check("t5_ok_after_clr", 32'(ok_pulse), 32'd1);
      idle(1);

      // 6: reset mid-lockout and mid-programming
      for (int i = 0; i < 3; i++) begin
         submit(24'h111111);
         idle(2);
      end
      check("t6_in_lockout", 32'(lockout), 32'd1);
      idle(10);
      cyc(1'b0, 4'h0, 1'b1);
      check("t6_rst_lockout", 32'(lockout), 32'd0);
      check("t6_rst_locked", 32'(locked), 32'd0);
      check("t6_rst_fails", 32'(fail_count), 32'd0);
      submit(MASTER);
      idle(1);
      type_code(24'h777777);
      cyc(1'b0, 4'h0, 1'b1);
      check("t6_rst_prog", 32'(prog_mode), 32'd0);
      check("t6_rst_digits", 32'(digits_entered), 32'd0);
      submit(24'h666666);
      idle(1);
      check("t6_default_back", 32'(ok_pulse), 32'd1);
      idle(1);

      // randomized sessions
      for (int s = 0; s < 300; s++) begin
         rr = $urandom_range(0, 99);
         if (rr < 3) begin
            cyc(1'b0, 4'h0, 1'b1);
         end else if (rr < 6) begin
            idle(ET + $urandom_range(0, 2) - 1);
         end else begin
            sel = $urandom_range(0, 3);
            case (sel)
               0: code = m_user;
               1: code = MASTER;
               2: code = m_cand;
               default: for (int i = 0; i < N; i++) code[4*i +: 4] = 4'($urandom_range(0, 9));
            endcase
            nd = ($urandom_range(0, 9) < 7) ? N : $urandom_range(4, 8);
            for (int i = 0; i < nd; i++) begin
               if ($urandom_range(0, 99) < 4) press(4'($urandom_range(10, 15)));
               if (i < N) press(code[4*(N-1-i) +: 4]);
               else       press(4'($urandom_range(0, 9)));
            end
            if ($urandom_range(0, 9) != 0) press(KEY_ENTER);
            idle($urandom_range(0, 3));
         end
      end
      idle(LC + 5);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
